// File: rtl/alu4_pkg.sv
// rtl/alu4_pkg.sv - shared opcode, flag and width definitions for the alu4 datapath
package alu4_pkg;

    localparam int ALU4_WIDTH = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_OR  = 2'b11
    } op_e;

    typedef struct packed {
        logic carry;
        logic zero;
        logic overflow;
    } alu_flags_t;

endpackage

// File: rtl/alu4_if.sv
// rtl/alu4_if.sv - operand/opcode request and registered result bundle of alu4
interface alu4_if import alu4_pkg::*; #(
    parameter int WIDTH = ALU4_WIDTH
) ();

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       alu_sel;
    logic             out_valid;
    logic [WIDTH-1:0] alu_out;
    logic             carry;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, a, b, alu_sel,
        input  out_valid, alu_out, carry, zero, overflow
    );

    modport slave (
        input  in_valid, a, b, alu_sel,
        output out_valid, alu_out, carry, zero, overflow
    );

endinterface

// File: rtl/alu4_core.sv
// rtl/alu4_core.sv - combinational add/sub/and/or unit with carry, zero and overflow flags
module alu4_core import alu4_pkg::*; #(
    parameter int WIDTH = ALU4_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  op_e              i_op,
    output logic [WIDTH-1:0] o_result,
    output alu_flags_t       o_flags
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // The extra top bit of the widened difference is the unsigned borrow.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result = '0;
        o_flags  = '0;
        case (i_op)
            OP_ADD: begin
                o_result         = w_sum[MSB:0];
                o_flags.carry    = w_sum[WIDTH];
                o_flags.overflow = (i_a[MSB] == i_b[MSB]) && (w_sum[MSB] != i_a[MSB]);
            end
            OP_SUB: begin
                o_result         = w_diff[MSB:0];
                o_flags.carry    = w_diff[WIDTH];
                o_flags.overflow = (i_a[MSB] != i_b[MSB]) && (w_diff[MSB] != i_a[MSB]);
            end
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
        endcase
        o_flags.zero = (o_result == '0);
    end

endmodule

// File: rtl/alu4.sv
// rtl/alu4.sv - registered ALU top: input qualification, result/flag registers, out_valid strobe
module alu4 import alu4_pkg::*; #(
    parameter int WIDTH = ALU4_WIDTH
) (
    input  logic   clk,
    input  logic   rst,
    alu4_if.slave  bus
);

    logic [WIDTH-1:0] w_result;
    alu_flags_t       w_flags;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_alu_out;
    alu_flags_t       r_flags;

    alu4_core #(.WIDTH(WIDTH)) u_core (
        .i_a      (bus.a),
        .i_b      (bus.b),
        .i_op     (op_e'(bus.alu_sel)),
        .o_result (w_result),
        .o_flags  (w_flags)
    );

    // Result and flags only update on accepted inputs; idle cycles hold them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_alu_out   <= '0;
            r_flags     <= '0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_alu_out <= w_result;
                r_flags   <= w_flags;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.alu_out   = r_alu_out;
    assign bus.carry     = r_flags.carry;
    assign bus.zero      = r_flags.zero;
    assign bus.overflow  = r_flags.overflow;

endmodule

// File: tb/tb_alu4.sv
// tb/tb_alu4.sv - self-checking bench for alu4: directed cases, exhaustive sweep, random hold traffic
module tb_alu4;

    localparam int W    = 4;
    localparam int M    = 1 << W;
    localparam int HALF = 1 << (W - 1);

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    alu4_if #(.WIDTH(W)) bus ();

    alu4 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W+3:0] pack(input logic v, input int res, input logic c,
                                          input logic z, input logic ov);
        logic [W-1:0] r;
        r = res[W-1:0];
        return {v, r, c, z, ov};
    endfunction

    // Reference: plain integer arithmetic, overflow judged by signed range.
    function automatic logic [W+3:0] model(input int a, input int b, input int sel);
        int   r;
        int   sa;
        int   sb;
        int   sr;
        logic c;
        logic ov;
        sa = (a >= HALF) ? a - M : a;
        sb = (b >= HALF) ? b - M : b;
        c  = 1'b0;
        ov = 1'b0;
        case (sel)
            0: begin
                r  = a + b;
                c  = (r >= M);
                r  = r % M;
                sr = sa + sb;
                ov = (sr > HALF - 1) || (sr < -HALF);
            end
            1: begin
                c  = (a < b);
                r  = (a - b + M) % M;
                sr = sa - sb;
                ov = (sr > HALF - 1) || (sr < -HALF);
            end
            2: r = a & b;
            default: r = a | b;
        endcase
        return pack(1'b1, r, c, (r == 0), ov);
    endfunction

    task automatic chk(input string tag, input logic [W+3:0] exp);
        logic [W+3:0] obs;
        obs = {bus.out_valid, bus.alu_out, bus.carry, bus.zero, bus.overflow};
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed v=%b out=%0d c=%b z=%b ov=%b, expected v=%b out=%0d c=%b z=%b ov=%b",
                   tag, obs[W+3], obs[W+2:3], obs[2], obs[1], obs[0],
                   exp[W+3], exp[W+2:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic go(input logic v, input int a, input int b, input int sel);
        bus.in_valid = v;
        bus.a        = a[W-1:0];
        bus.b        = b[W-1:0];
        bus.alu_sel  = sel[1:0];
        @(negedge clk);
    endtask

    initial begin
        logic [W+3:0] exp;
        int           ra;
        int           rb;
        int           rs;
        logic         rv;

        vectors      = 0;
        miscompares  = 0;
        clk          = 1'b0;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.alu_sel  = '0;

        #1 rst = 1'b1;
        #1 chk("reset_initial", pack(0, 0, 0, 0, 0));
        @(negedge clk);
        chk("reset_held", pack(0, 0, 0, 0, 0));
        rst = 1'b0;

        go(1, 6, 2, 0); chk("add_6_2", pack(1, 8, 0, 0, 1));
        go(1, 6, 2, 1); chk("sub_6_2", pack(1, 4, 0, 0, 0));
        go(1, 6, 2, 2); chk("and_6_2", pack(1, 2, 0, 0, 0));
        go(1, 6, 2, 3); chk("or_6_2",  pack(1, 6, 0, 0, 0));

        go(1, 15, 1, 0); chk("add_wrap",  pack(1, 0, 1, 1, 0));
        go(1, 2, 6, 1);  chk("sub_borrow", pack(1, 12, 1, 0, 0));
        go(1, 8, 1, 1);  chk("sub_ovf",   pack(1, 7, 0, 0, 1));

        go(1, 3, 4, 0);  chk("hold_load", pack(1, 7, 0, 0, 0));
        go(0, 12, 9, 1); chk("hold_1",    pack(0, 7, 0, 0, 0));
        go(0, 5, 15, 2); chk("hold_2",    pack(0, 7, 0, 0, 0));
        go(0, 0, 0, 3);  chk("hold_3",    pack(0, 7, 0, 0, 0));

        // Mid-cycle asynchronous reset after a valid result, inputs still valid.
        go(1, 9, 9, 0);  chk("pre_reset", pack(1, 2, 1, 0, 1));
        #2 rst = 1'b1;
        #1 chk("reset_async", pack(0, 0, 0, 0, 0));
        @(negedge clk);
        chk("reset_over_edge", pack(0, 0, 0, 0, 0));
        rst = 1'b0;
        go(0, 9, 9, 0);  chk("post_reset_idle", pack(0, 0, 0, 0, 0));
        go(1, 15, 1, 0); chk("post_reset_first", pack(1, 0, 1, 1, 0));

        for (int s = 0; s < 4; s++) begin
            for (int a = 0; a < M; a++) begin
                for (int b = 0; b < M; b++) begin
                    go(1, a, b, s);
                    chk($sformatf("sweep_s%0d_a%0d_b%0d", s, a, b), model(a, b, s));
                end
            end
        end

        exp = model(M - 1, M - 1, 3);
        for (int i = 0; i < 300; i++) begin
            rv = 1'($urandom_range(0, 1));
            ra = int'($urandom_range(0, M - 1));
            rb = int'($urandom_range(0, M - 1));
            rs = int'($urandom_range(0, 3));
            go(rv, ra, rb, rs);
            if (rv) exp = model(ra, rb, rs);
            else    exp[W+3] = 1'b0;
            chk($sformatf("rand_%0d", i), exp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu4.md
Name: alu4

Overview:
- 4-bit (parameterisable) registered ALU: add, subtract, bitwise AND, bitwise OR on two operands, selected by a 2-bit opcode.
- Produces a result word plus a carry/borrow flag, zero flag and signed-overflow flag.
- Operands and opcode are sampled on one clock edge; results are registered and presented one cycle later with a valid strobe.
- Sits as a leaf datapath unit feeding simple datapath/control blocks.

Parameters:
- WIDTH, 4, operand/result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/opcode valid this cycle.
- a  input  WIDTH  operand A, unsigned (also read as two's complement for overflow).
- b  input  WIDTH  operand B.
- alu_sel  input  2  opcode: 00 ADD, 01 SUB, 10 AND, 11 OR.
- out_valid  output  1  alu_out and flags hold a new result this cycle.
- alu_out  output  WIDTH  result.
- carry  output  1  ADD: carry out; SUB: borrow (1 when a < b unsigned); AND/OR: 0.
- zero  output  1  1 when the result equals 0.
- overflow  output  1  signed overflow for ADD/SUB; 0 for AND/OR.

Behaviour:
- Reset (asynchronous, active-high): alu_out=0, carry=0, zero=0, overflow=0, out_valid=0, taking effect immediately without a clock. Outputs stay at these values while rst=1.
- Latency is 1 cycle. At a rising edge with in_valid=1, the block computes from the current a, b and alu_sel and registers the result. out_valid=1 in the following cycle.
- At a rising edge with in_valid=0: out_valid goes to 0 and alu_out and all flags hold their previous values.
- Back-to-back in_valid=1 gives one result per cycle. There is no backpressure.
- ADD: {carry, alu_out} = a + b computed at WIDTH+1 bits. overflow = (a[MSB]==b[MSB]) and (alu_out[MSB]!=a[MSB]).
- SUB: alu_out = (a - b) mod 2^WIDTH. carry = (a < b) unsigned borrow. overflow = (a[MSB]!=b[MSB]) and (alu_out[MSB]!=a[MSB]).
- AND: alu_out = a & b. OR: alu_out = a | b. For both, carry=0 and overflow=0.
- zero is derived from the registered result value and is valid whenever out_valid=1.
- Wrap-around: ADD with a sum of 2^WIDTH or more wraps the result and sets carry. SUB with a < b wraps and sets borrow.
- Deasserting rst mid-stream: the first input is accepted at the first rising edge with rst=0 and in_valid=1.
- The opcode is fully decoded. There is no illegal encoding and no X propagation from the select.

Decomposition:
- Package alu4_pkg holds:
  - enum op_e (OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11);
  - a struct alu_flags_t {carry, zero, overflow};
  - the default WIDTH constant.
- Sub-module alu4_core: a purely combinational unit (a, b, op) -> (result, flags).
- The top level alu4 adds the input-valid qualification, the output registers with asynchronous reset, and the out_valid pipeline bit.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after a valid result. Required: all outputs go to 0 immediately; out_valid=0 until a new valid input is accepted.
- a=6, b=2, in_valid=1, sel cycled 00,01,10,11 on consecutive cycles. Required, each one cycle later with out_valid=1:
  - ADD: 8, carry=0, overflow=1 (6+2 overflows 4-bit signed);
  - SUB: 4, carry=0, overflow=0;
  - AND: 2, carry=0;
  - OR: 6, carry=0.
  All zero=0.
- Carry and wrap: a=15, b=1, ADD. Required: alu_out=0, carry=1, zero=1, overflow=0.
- Borrow: a=2, b=6, SUB. Required: alu_out=12, carry=1, overflow=0. Then a=8, b=1, SUB. Required: alu_out=7, carry=0, overflow=1.
- Hold: valid ADD 3+4, then in_valid=0 for 3 cycles while a, b and sel toggle. Required: alu_out stays at 7, out_valid=1 for one cycle then 0.
- Exhaustive sweep: every a, b (0..15) and each opcode, checked against a reference model of all four outputs.
